// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous memory between instruction fetch (IF) and
// load/store (DATA). DATA has priority; a starvation counter bounds IF losses.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);
  localparam logic [3:0] SMAX     = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  logic       owner_d, owner_d_nxt;
  logic       we_flag, we_flag_nxt;
  logic [2:0] lat_cnt, lat_cnt_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       resp, window, gnt_d, gnt_if;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      we_flag    <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner_d    <= owner_d_nxt;
      we_flag    <= we_flag_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_d_nxt = owner_d;
    we_flag_nxt = we_flag;
    lat_cnt_nxt = lat_cnt;
    starve_nxt  = starve_cnt;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    if_rvalid   = 1'b0;
    d_rvalid    = 1'b0;
    if_rdata    = '0;
    d_rdata     = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = '0;
    busy        = 1'b0;
    resp        = (state == WAIT) && (lat_cnt == LAT_LAST);
    window      = (state == IDLE) || resp;
    // Outputs are forced low while reset is asserted, even if state is still WAIT.
    gnt_d       = !reset && window && d_req && !(if_req && starve_cnt == SMAX);
    gnt_if      = !reset && window && if_req && !gnt_d;

    if (!reset) begin
      busy = (state == WAIT);
      if (resp) begin
        if (owner_d) begin
          d_rvalid = 1'b1;
          d_rdata  = we_flag ? '0 : mem_rdata;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
        state_nxt   = IDLE;
        lat_cnt_nxt = '0;
      end else if (state == WAIT) begin
        lat_cnt_nxt = lat_cnt + 3'd1;
      end

      // A grant in the response cycle overrides the return to IDLE.
      if (gnt_d) begin
        d_gnt       = 1'b1;
        mem_en      = 1'b1;
        mem_we      = d_we;
        mem_addr    = d_addr >> 2;
        mem_wdata   = d_wdata;
        mem_be      = d_we ? d_be : 4'hF;
        owner_d_nxt = 1'b1;
        we_flag_nxt = d_we;
        state_nxt   = WAIT;
        lat_cnt_nxt = '0;
      end else if (gnt_if) begin
        if_gnt      = 1'b1;
        mem_en      = 1'b1;
        mem_addr    = if_addr >> 2;
        mem_be      = 4'hF;
        owner_d_nxt = 1'b0;
        we_flag_nxt = 1'b0;
        state_nxt   = WAIT;
        lat_cnt_nxt = '0;
      end

      if (!if_req || gnt_if) starve_nxt = '0;
      else if (gnt_d)        starve_nxt = starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Checks mem_port_arbiter against a transaction-level model that tracks the
// pending access by its response cycle number and IF losses as an integer.
module tb_mem_port_arbiter;
  localparam int unsigned L  = 3;
  localparam int unsigned SM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] rd_word = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] hash(input logic [31:0] w);
    return (w * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  // Memory stand-in: read data for the last read word holds until the next read.
  always @(posedge clk) if (mem_en && !mem_we) rd_word <= mem_addr;
  assign mem_rdata = hash(rd_word);

  int          total = 0, bad = 0;
  int          cyc = 0, resp_at = 0, losses = 0;
  bit          pend = 0, pend_d = 0, keep_if = 0, keep_d = 0;
  logic [31:0] pend_data = '0;
  string       obs_seq = "";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = $urandom;
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom);
    d_addr  = $urandom;
    d_wdata = $urandom;
    d_be    = 4'($urandom);
  endtask

  // One clock: check outputs against the model, then advance model and requesters.
  task automatic step();
    bit rv, win, e_dg, e_ifg;
    e_dg = 0;
    e_ifg = 0;
    #2;
    if (d_gnt)  obs_seq = {obs_seq, "D"};
    if (if_gnt) obs_seq = {obs_seq, "I"};
    if (reset) begin
      chk("rst_ctl", {21'b0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy, mem_be}, '0);
      chk("rst_data", if_rdata | d_rdata | mem_addr | mem_wdata, '0);
      pend   = 0;
      losses = 0;
    end else begin
      rv    = pend && (cyc == resp_at);
      win   = !pend || rv;
      e_dg  = win && d_req && !(if_req && losses >= SM);
      e_ifg = win && if_req && !e_dg;
      chk("if_gnt", if_gnt, e_ifg);
      chk("d_gnt", d_gnt, e_dg);
      chk("mem_en", mem_en, e_dg | e_ifg);
      chk("busy", busy, pend);
      chk("if_rvalid", if_rvalid, rv && !pend_d);
      chk("d_rvalid", d_rvalid, rv && pend_d);
      if (rv) begin
        chk("if_rdata", if_rdata, pend_d ? '0 : pend_data);
        chk("d_rdata", d_rdata, pend_d ? pend_data : '0);
      end
      if (e_dg) begin
        chk("d_mem_we", mem_we, d_we);
        chk("d_mem_addr", mem_addr, d_addr / 4);
        chk("d_mem_be", mem_be, d_we ? d_be : 4'hF);
        chk("d_mem_wdata", mem_wdata, d_wdata);
      end
      if (e_ifg) begin
        chk("if_mem_we", mem_we, 0);
        chk("if_mem_addr", mem_addr, if_addr / 4);
        chk("if_mem_be", mem_be, 4'hF);
      end
      if (!if_req || e_ifg) losses = 0;
      else if (e_dg)        losses++;
      if (e_dg || e_ifg) begin
        pend      = 1;
        resp_at   = cyc + L;
        pend_d    = e_dg;
        pend_data = e_dg ? (d_we ? '0 : hash(d_addr / 4)) : hash(if_addr / 4);
      end else if (rv) begin
        pend = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (e_dg)  begin if (keep_d)  new_d();  else d_req  = 1'b0; end
    if (e_ifg) begin if (keep_if) new_if(); else if_req = 1'b0; end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (if_req || d_req || pend); i++) step();
    chk("drain_timeout", {if_req, d_req, pend}, 0);
  endtask

  initial begin
    reset = 1'b1; if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    @(posedge clk); #1;

    // Reset held with both requests pending, then DATA wins first.
    new_if(); new_d(); d_we = 1'b0;
    step(); step();
    reset = 1'b0;
    obs_seq = "";
    step();
    chk("post_reset_first_gnt", obs_seq == "D", 1);
    drain();

    // IF read and a directed store.
    if_req = 1'b1; if_addr = 32'h0000_8000;
    drain();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
    drain();

    // Both requesters saturate: four DATA wins, then one IF win.
    obs_seq = ""; keep_d = 1; keep_if = 1;
    new_if(); new_d();
    repeat (6 * L) step();
    chk("starve_seq", obs_seq == "DDDDID", 1);
    keep_d = 0; keep_if = 0;
    drain();

    // Load latency with an IF request arriving while it is in flight.
    new_d(); d_we = 1'b0;
    step();
    new_if();
    drain();

    // Reset one cycle after an IF grant abandons that access.
    new_if();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (2 * L) step();

    // Random traffic with occasional resets.
    repeat (500) begin
      if (!if_req && $urandom_range(2) == 0) new_if();
      if (!d_req && $urandom_range(1) == 0) new_d();
      reset = ($urandom_range(60) == 0);
      step();
    end
    reset = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
